// File: rtl/modbus_pkg.sv
// Shared Modbus RTU definitions: receiver state encoding, CRC-16/Modbus
// constants and a byte-wide CRC update used by the receive and transmit paths.
package modbus_pkg;

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        RECV,
        GAP,
        DONE
    } rtu_rx_state_t;

    localparam logic [15:0] CRC_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC_POLY    = 16'hA001;
    localparam int          MIN_ADU_LEN = 4;

    // One whole byte through the reflected CRC, LSB first (eight shift/XOR steps).
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/modbus_crc16.sv
// Registered CRC-16/Modbus accumulator. clear_i restarts from CRC_INIT; when
// clear_i and en_i coincide the byte is folded into a fresh CRC.
module modbus_crc16
    import modbus_pkg::*;
(
    input  logic        clk_i,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] base;

    // Starting point for this byte: fresh seed on clear, otherwise running value.
    always_comb begin
        base = clear_i ? CRC_INIT : crc_q;
    end

    // Accumulate one byte per enable; a bare clear just reloads the seed.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            crc_q <= crc16_byte(base, data_i);
        end else if (clear_i) begin
            crc_q <= CRC_INIT;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/modbus_rtu_frame_rx.sv
// Modbus RTU receive framer: delimits frames by t1.5/t3.5 bus silence, writes
// frame bytes to the buffer, checks CRC on the fly and holds frame status
// until the register-space controller acknowledges it.
module modbus_rtu_frame_rx
    import modbus_pkg::*;
#(
    parameter int T15_CLKS = 1563,
    parameter int T35_CLKS = 3646,
    parameter int MAX_LEN  = 256
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_ferr,
    output logic       o_buf_we,
    output logic [7:0] o_buf_addr,
    output logic [7:0] o_buf_data,
    output logic       o_frame_valid,
    output logic [8:0] o_frame_len,
    output logic       o_crc_ok,
    output logic       o_frame_err,
    input  logic       i_frame_ack,
    output logic       o_overrun
);

    localparam int                CNT_W = $clog2(T35_CLKS + 1);
    localparam logic [CNT_W-1:0]  T15_C = CNT_W'(T15_CLKS);
    localparam logic [CNT_W-1:0]  T35_C = CNT_W'(T35_CLKS);
    localparam logic [8:0]        MAX_L = 9'(MAX_LEN);
    localparam logic [8:0]        MIN_L = 9'(MIN_ADU_LEN);

    rtu_rx_state_t    state_q, state_d;
    logic [CNT_W-1:0] sil_q, sil_d;
    logic [8:0]       len_q, len_d;
    logic             err_q, err_d;
    logic             we_q, we_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             fv_q, fv_d;
    logic [8:0]       flen_q, flen_d;
    logic             crcok_q, crcok_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             crc_clear;
    logic             crc_en;
    logic [15:0]      crc;

    modbus_crc16 u_crc (
        .clk_i   (i_clk),
        .clear_i (crc_clear),
        .en_i    (crc_en),
        .data_i  (i_rx_data),
        .crc_o   (crc)
    );

    // Next-state, silence timing, buffer write and status latching.
    always_comb begin
        state_d   = state_q;
        sil_d     = i_rx_valid ? '0 : ((sil_q == T35_C) ? sil_q : sil_q + CNT_W'(1));
        len_d     = len_q;
        err_d     = err_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        fv_d      = fv_q;
        flen_d    = flen_q;
        crcok_d   = crcok_q;
        ferr_d    = ferr_q;
        ovr_d     = ovr_q;
        crc_clear = 1'b0;
        crc_en    = 1'b0;
        case (state_q)
            SYNC: begin
                if (!i_rx_valid && sil_q == T35_C) state_d = IDLE;
            end
            IDLE: begin
                if (i_rx_valid) begin
                    state_d   = RECV;
                    len_d     = 9'd1;
                    err_d     = i_rx_ferr;
                    crc_clear = 1'b1;
                    crc_en    = 1'b1;
                    we_d      = 1'b1;
                    addr_d    = 8'd0;
                    data_d    = i_rx_data;
                end
            end
            RECV, GAP: begin
                if (i_rx_valid) begin
                    state_d = RECV;
                    if (len_q < MAX_L) begin
                        we_d   = 1'b1;
                        addr_d = len_q[7:0];
                        data_d = i_rx_data;
                        len_d  = len_q + 9'd1;
                        crc_en = 1'b1;
                        err_d  = err_q | i_rx_ferr | (state_q == GAP);
                    end else begin
                        // Buffer full: byte is neither stored nor counted.
                        err_d = 1'b1;
                    end
                end else if (state_q == RECV && sil_q >= T15_C) begin
                    state_d = GAP;
                end else if (state_q == GAP && sil_q == T35_C) begin
                    state_d = DONE;
                    fv_d    = 1'b1;
                    flen_d  = len_q;
                    crcok_d = (crc == 16'h0000) && (len_q >= MIN_L) && !err_q;
                    ferr_d  = err_q || (len_q < MIN_L);
                end
            end
            DONE: begin
                // Ack takes priority over a colliding byte, leaving overrun clear.
                if (i_frame_ack) begin
                    state_d = IDLE;
                    fv_d    = 1'b0;
                    ovr_d   = 1'b0;
                end else if (i_rx_valid) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    // State and output registers with synchronous reset back to bus sync.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= SYNC;
            sil_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            fv_q    <= 1'b0;
            flen_q  <= '0;
            crcok_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sil_q   <= sil_d;
            len_q   <= len_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            fv_q    <= fv_d;
            flen_q  <= flen_d;
            crcok_q <= crcok_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_buf_we      = we_q;
    assign o_buf_addr    = addr_q;
    assign o_buf_data    = data_q;
    assign o_frame_valid = fv_q;
    assign o_frame_len   = flen_q;
    assign o_crc_ok      = crcok_q;
    assign o_frame_err   = ferr_q;
    assign o_overrun     = ovr_q;

endmodule

// File: tb/tb_modbus_rtu_frame_rx.sv
// Bench for modbus_rtu_frame_rx: directed and randomized frames checked
// against a queue-based frame model with a bit-serial CRC reference.
module tb_modbus_rtu_frame_rx;

    localparam int T15  = 15;
    localparam int T35  = 35;
    localparam int MAXL = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ferr = 1'b0;
    logic       ack = 1'b0;
    logic       buf_we;
    logic [7:0] buf_addr;
    logic [7:0] buf_data;
    logic       fv;
    logic [8:0] flen;
    logic       crc_ok;
    logic       ferr;
    logic       ovr;

    modbus_rtu_frame_rx #(.T15_CLKS(T15), .T35_CLKS(T35), .MAX_LEN(MAXL)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_rx_valid    (rx_valid),
        .i_rx_data     (rx_data),
        .i_rx_ferr     (rx_ferr),
        .o_buf_we      (buf_we),
        .o_buf_addr    (buf_addr),
        .o_buf_data    (buf_data),
        .o_frame_valid (fv),
        .o_frame_len   (flen),
        .o_crc_ok      (crc_ok),
        .o_frame_err   (ferr),
        .i_frame_ack   (ack),
        .o_overrun     (ovr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Captured buffer writes, sampled mid-cycle.
    int wr_addr[$];
    int wr_data[$];
    always @(negedge clk) begin
        if (buf_we) begin
            wr_addr.push_back(int'(buf_addr));
            wr_data.push_back(int'(buf_data));
        end
    end

    // Current frame description: bytes, framing-error flags, error-gap-before flags.
    logic [7:0] fb[$];
    bit         fe[$];
    bit         fg[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC-16/Modbus over the first n frame bytes, one bit at a time.
    function automatic logic [15:0] ref_crc(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ fb[i][b]) c = (c >> 1) ^ 16'hA001;
                else                 c = c >> 1;
            end
        end
        return c;
    endfunction

    task automatic clear_frame();
        fb.delete();
        fe.delete();
        fg.delete();
    endtask

    task automatic add_byte(input logic [7:0] d, input bit f, input bit g);
        fb.push_back(d);
        fe.push_back(f);
        fg.push_back(g);
    endtask

    // One byte strobe; called and returns just after a falling edge.
    task automatic send(input logic [7:0] d, input bit f, input int gap);
        rx_valid = 1'b1;
        rx_data  = d;
        rx_ferr  = f;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Sends the described frame, waits for frame end and checks status and writes.
    task automatic run_frame(input string tag, input int fixed_gap);
        int  n, len, cyc, mism, gap;
        bit  err, exp_ok, exp_err;
        n = fb.size();
        wr_addr.delete();
        wr_data.delete();
        for (int i = 0; i < n; i++) begin
            if (i == n - 1)           gap = 0;
            else if (fg[i+1])         gap = (fixed_gap > 0) ? 25 : int'($urandom_range(T35 - 3, T15 + 3));
            else                      gap = (fixed_gap > 0) ? fixed_gap : int'($urandom_range(T15 - 3, 1));
            send(fb[i], fe[i], gap);
        end
        cyc = 0;
        while (!fv && cyc < T35 + 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_fv_delay"}, cyc, T35 + 1);
        len = (n > MAXL) ? MAXL : n;
        err = (n > MAXL);
        for (int i = 0; i < n; i++) err = err | fe[i] | ((i > 0) && fg[i]);
        exp_ok  = (ref_crc(len) == 16'h0000) && (len >= 4) && !err;
        exp_err = err || (len < 4);
        chk({tag, "_len"}, flen, len);
        chk({tag, "_crc_ok"}, crc_ok, exp_ok);
        chk({tag, "_err"}, ferr, exp_err);
        chk({tag, "_nwr"}, wr_addr.size(), len);
        mism = 0;
        for (int i = 0; i < wr_addr.size() && i < len; i++) begin
            if (wr_addr[i] != i || wr_data[i] != int'(fb[i])) mism++;
        end
        chk({tag, "_wr_content"}, mism, 0);
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk({tag, "_ack_fv"}, fv, 0);
        chk({tag, "_ack_ovr"}, ovr, 0);
    endtask

    task automatic load_good(input logic [7:0] last);
        clear_frame();
        add_byte(8'h01, 0, 0); add_byte(8'h03, 0, 0); add_byte(8'h00, 0, 0); add_byte(8'h00, 0, 0);
        add_byte(8'h00, 0, 0); add_byte(8'h0A, 0, 0); add_byte(8'hC5, 0, 0); add_byte(last, 0, 0);
    endtask

    initial begin
        int nwr, n, seen;
        logic [15:0] c;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_fv", fv, 0);
        chk("rst_len", flen, 0);
        chk("rst_crc_ok", crc_ok, 0);
        chk("rst_err", ferr, 0);
        chk("rst_we", buf_we, 0);
        chk("rst_ovr", ovr, 0);
        rst = 1'b0;

        // Bytes during initial silence window are ignored
        wr_addr.delete();
        send(8'h55, 0, 5);
        send(8'hAA, 0, 5);
        send(8'h01, 0, 5);
        repeat (T35 + 5) @(negedge clk);
        chk("sync_nwr", wr_addr.size(), 0);
        chk("sync_fv", fv, 0);

        // Known-good frame
        load_good(8'hCD);
        run_frame("good", 10);
        chk("good_len_c", flen, 8);
        chk("good_ok_c", crc_ok, 1);
        chk("good_err_c", ferr, 0);
        do_ack("good");

        // Corrupted CRC
        load_good(8'hCC);
        run_frame("badcrc", 10);
        chk("badcrc_ok_c", crc_ok, 0);
        chk("badcrc_err_c", ferr, 0);
        do_ack("badcrc");

        // Gap error between byte 3 and byte 4
        load_good(8'hCD);
        fg[3] = 1;
        run_frame("gap", 10);
        chk("gap_err_c", ferr, 1);
        chk("gap_ok_c", crc_ok, 0);
        chk("gap_len_c", flen, 8);
        do_ack("gap");

        // Short frame
        clear_frame();
        add_byte(8'h01, 0, 0); add_byte(8'h03, 0, 0); add_byte(8'h00, 0, 0);
        run_frame("short", 10);
        chk("short_err_c", ferr, 1);
        do_ack("short");

        // Overlength frame
        clear_frame();
        for (int i = 0; i < 260; i++) add_byte(8'($urandom), 0, 0);
        run_frame("long", 1);
        chk("long_len_c", flen, 256);
        chk("long_err_c", ferr, 1);
        do_ack("long");

        // Overrun while holding off the ack
        load_good(8'hCD);
        run_frame("ovr", 10);
        nwr = wr_addr.size();
        send(8'h11, 0, 3);
        send(8'h22, 0, 3);
        chk("ovr_set", ovr, 1);
        chk("ovr_nwr", wr_addr.size(), nwr);
        chk("ovr_fv_held", fv, 1);
        do_ack("ovr");

        // Ack colliding with a byte in DONE
        load_good(8'hCD);
        run_frame("coll", 10);
        nwr = wr_addr.size();
        rx_valid = 1'b1; rx_data = 8'h77; ack = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("coll_ovr", ovr, 0);
        chk("coll_fv", fv, 0);
        chk("coll_nwr", wr_addr.size(), nwr);

        // Randomized frames
        for (int k = 0; k < 10; k++) begin
            clear_frame();
            n = int'($urandom_range(14, 1));
            for (int i = 0; i < n; i++) add_byte(8'($urandom), ($urandom_range(7, 0) == 0), (i > 0) && ($urandom_range(7, 0) == 0));
            if ($urandom_range(1, 0) == 1) begin
                c = ref_crc(fb.size());
                add_byte(c[7:0], 0, 0);
                add_byte(c[15:8], 0, 0);
            end
            run_frame($sformatf("rnd%0d", k), 0);
            do_ack($sformatf("rnd%0d", k));
        end

        // Reset mid-frame abandons the partial frame
        send(8'h01, 0, 5);
        send(8'h03, 0, 5);
        send(8'h00, 0, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 2 * T35 + 10; i++) begin
            @(negedge clk);
            if (fv) seen++;
        end
        chk("midrst_no_fv", seen, 0);
        load_good(8'hCD);
        run_frame("after_rst", 10);
        chk("after_rst_ok_c", crc_ok, 1);
        do_ack("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
